vliw_fetch_queue: RTL

Parametrised fetch/issue front end for the VLIW core. It replaces the combinational single-bundle fetch path with a registered bundle queue. Each cycle it reads one NUM_SLOTS-wide bundle from instruction memory, buffers it with its PC, and presents it to decode under a valid/ready handshake. It also handles branch redirect, queue flush and decode stall.

---
 rtl/vliw_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/vliw_fetch_queue.sv | 98 +++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared constants and types for the VLIW fetch front end.
// The optional combinational bypass is enabled by defining VLIW_FETCH_BYPASS_EN.
package vliw_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam int          DEF_NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_IXU1   = 2'd0,
        SLOT_IXU2   = 2'd1,
        SLOT_LSU    = 2'd2,
        SLOT_BRANCH = 2'd3
    } slot_e;

    // Slot 0 sits in the least significant bits, matching the memory bundle layout.
    typedef struct packed {
        logic [31:0]                    pc;
        logic [DEF_NUM_SLOTS-1:0][31:0] inst;
    } bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush and occupancy count, async active-low reset.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 160
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata     = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/vliw_fetch_queue.sv
// Registered bundle fetch queue with redirect, flush and decode stall handling.
// Defining VLIW_FETCH_BYPASS_EN lets an empty queue forward the memory bundle combinationally.
module vliw_fetch_queue
    import vliw_pkg::*;
#(
    parameter int                NUM_SLOTS = 4,
    parameter int                INST_W    = 32,
    parameter int                PC_W      = 32,
    parameter int                DEPTH     = 4,
    parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [PC_W-1:0]               mem_pc,
    input  logic [NUM_SLOTS*INST_W-1:0]   mem_bundle,
    input  logic                          branch_taken,
    input  logic [PC_W-1:0]               new_pc,
    input  logic                          issue_ready,
    output logic                          issue_valid,
    output logic [PC_W-1:0]               issue_pc,
    output logic [NUM_SLOTS*INST_W-1:0]   issue_bundle,
    output logic                          squash_out,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int                        BUNDLE_W   = NUM_SLOTS*INST_W;
    localparam int                        ENTRY_W    = PC_W + BUNDLE_W;
    localparam int                        OCC_W      = $clog2(DEPTH+1);
    localparam logic [PC_W-1:0]           PC_STEP    = PC_W'(NUM_SLOTS*(INST_W/8));
    localparam logic [INST_W-1:0]         NOP_SLOT   = INST_W'(NOP_INST);
    localparam logic [BUNDLE_W-1:0]       NOP_BUNDLE = {NUM_SLOTS{NOP_SLOT}};

    logic [PC_W-1:0]    fetch_pc;
    logic [ENTRY_W-1:0] head;
    logic [OCC_W-1:0]   occ;
    logic               empty;
    logic               full;
    logic               push;
    logic               fifo_pop;
    logic               advance;
`ifdef VLIW_FETCH_BYPASS_EN
    logic               bypass;
    logic               consume_bypass;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (fifo_pop),
        .flush     (branch_taken),
        .wdata     ({fetch_pc, mem_bundle}),
        .rdata     (head),
        .occupancy (occ)
    );

    // A redirect overrides the handshake: nothing is pushed or popped in that cycle.
    always_comb begin
        empty        = (occ == '0);
        full         = (occ == OCC_W'(DEPTH));
        issue_valid  = !empty && !branch_taken;
        fifo_pop     = issue_valid && issue_ready;
        push         = !branch_taken && (!full || fifo_pop);
        advance      = push;
        issue_pc     = fetch_pc;
        issue_bundle = NOP_BUNDLE;
        if (issue_valid) {issue_pc, issue_bundle} = head;
`ifdef VLIW_FETCH_BYPASS_EN
        bypass         = empty && !branch_taken;
        consume_bypass = bypass && issue_ready;
        issue_valid    = !branch_taken;
        push           = !branch_taken && (!full || fifo_pop) && !consume_bypass;
        advance        = push || consume_bypass;
        if (bypass) begin
            issue_pc     = fetch_pc;
            issue_bundle = mem_bundle;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            squash_out <= 1'b0;
        end else begin
            squash_out <= branch_taken;
            if (branch_taken)  fetch_pc <= new_pc;
            else if (advance)  fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    assign mem_pc    = fetch_pc;
    assign occupancy = occ;

endmodule
